carry_slice_output_stage: RTL and testbench

//  Slice output stage sitting directly downstream of the fast carry chain.

---
 rtl/carry_slice_output_stage.sv | 183 ++++++++++++++++++
 tb/tb_carry_slice_output_stage.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/carry_slice_output_stage.sv
// Slice output stage behind the fast carry chain: optional output FF plus serial config loader.
// Latency: comb path 0 cycles, registered path 1 cycle; config applies on the cycle after commit.
// Backpressure: none; cfg_ready flags when a full shadow word is held and a commit will be taken.
//
// Ports:
//   clk, reset            single clock, synchronous active-high reset
//   lut_out, sum_in       candidate data sources for the output path
//   carry_in              carry from the chain, forwarded as carry_out_o
//   ce, sr                flip-flop enable (polarity from config) and sync set/reset
//   cfg_bit, cfg_shift    serial config stream, LSB first, qualified by cfg_shift
//   cfg_commit            apply the shadow word (taken only while cfg_ready is high)
//   cfg_ready, cfg_active loader status: word complete / a config has been applied
//   data_out, carry_out_o slice outputs, forced low until the first commit
//
// Optional feature macro: CARRY_OUT_REG_EN adds a carry-out register selected by config bit 5.
module carry_slice_output_stage #(
    parameter int   CFG_W    = 8,
    parameter logic INIT_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic lut_out,
    input  logic sum_in,
    input  logic carry_in,
    input  logic ce,
    input  logic sr,
    input  logic cfg_bit,
    input  logic cfg_shift,
    input  logic cfg_commit,
    output logic cfg_ready,
    output logic cfg_active,
    output logic data_out,
    output logic carry_out_o
);

    localparam int CNT_W = $clog2(CFG_W + 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CFG_W);

    // Bit 5 only matters when the carry-out register exists, so it is kept
    // in the active config only in that build.
`ifdef CARRY_OUT_REG_EN
    localparam int ACT_W = 6;
`else
    localparam int ACT_W = 5;
`endif

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [CFG_W-1:0]   shadow_q, shadow_d;
    logic [ACT_W-1:0]   active_cfg_q, active_cfg_d;
    logic               cfg_active_q, cfg_active_d;
    logic               ff_q, ff_d;
    logic               commit_fire;

    // Decoded fields of the live configuration.
    logic out_sel, d_sel, sr_val, ce_inv;
    logic d_mux, ce_eff, carry_sel;

    assign out_sel = active_cfg_q[0];
    assign d_sel   = active_cfg_q[1];
    assign sr_val  = active_cfg_q[2];
    assign ce_inv  = active_cfg_q[4];

    assign d_mux  = d_sel ? sum_in : lut_out;
    assign ce_eff = ce ^ ce_inv;

    // ------------------------------------------------------------------
    // Loader FSM: counts shifted bits, accepts commit only when full.
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        commit_fire = 1'b0;
        case (state_q)
            IDLE: begin
                if (cfg_shift) begin
                    count_d = CNT_ONE;
                    state_d = (CNT_ONE == CNT_FULL) ? FULL : SHIFT;
                end
            end
            SHIFT: begin
                if (cfg_shift) begin
                    count_d = count_q + CNT_ONE;
                    if (count_q + CNT_ONE == CNT_FULL) begin
                        state_d = FULL;
                    end
                end
            end
            FULL: begin
                if (cfg_commit) begin
                    commit_fire = 1'b1;
                    if (cfg_shift) begin
                        // The bit shifted alongside the commit starts the next word.
                        count_d = CNT_ONE;
                        state_d = (CNT_ONE == CNT_FULL) ? FULL : SHIFT;
                    end else begin
                        count_d = '0;
                        state_d = IDLE;
                    end
                end
                // A plain shift while full keeps sliding the window: the
                // newest CFG_W bits always form the word.
            end
            default: begin
                state_d = IDLE;
                count_d = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Shadow / active config and the output flip-flop.
    // ------------------------------------------------------------------
    always_comb begin
        shadow_d     = cfg_shift ? {cfg_bit, shadow_q[CFG_W-1:1]} : shadow_q;
        // Commit samples the shadow as it stood before any same-cycle shift.
        active_cfg_d = commit_fire ? shadow_q[ACT_W-1:0] : active_cfg_q;
        cfg_active_d = cfg_active_q | commit_fire;

        ff_d = ff_q;
        if (commit_fire) begin
            ff_d = shadow_q[3];
        end else if (cfg_active_q) begin
            if (sr) begin
                ff_d = sr_val;
            end else if (ce_eff) begin
                ff_d = d_mux;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            count_q      <= '0;
            shadow_q     <= '0;
            active_cfg_q <= '0;
            cfg_active_q <= 1'b0;
            ff_q         <= INIT_VAL;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            shadow_q     <= shadow_d;
            active_cfg_q <= active_cfg_d;
            cfg_active_q <= cfg_active_d;
            ff_q         <= ff_d;
        end
    end

    // ------------------------------------------------------------------
    // Carry forwarding.
    // ------------------------------------------------------------------
`ifdef CARRY_OUT_REG_EN
    logic carry_ff_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            carry_ff_q <= 1'b0;
        end else begin
            carry_ff_q <= carry_in;
        end
    end

    assign carry_sel = active_cfg_q[5] ? carry_ff_q : carry_in;
`else
    assign carry_sel = carry_in;
`endif

    // Outputs are gated by reset too so the reset cycle itself is quiet,
    // not only the cycles after the registers clear.
    assign cfg_ready   = (state_q == FULL) && !reset;
    assign cfg_active  = cfg_active_q;
    assign data_out    = !reset && cfg_active_q && (out_sel ? ff_q : d_mux);
    assign carry_out_o = !reset && cfg_active_q && carry_sel;

endmodule

// File: tb/tb_carry_slice_output_stage.sv
module tb_carry_slice_output_stage;

    logic clk = 1'b0;
    logic reset, lut_out, sum_in, carry_in, ce, sr;
    logic cfg_bit, cfg_shift, cfg_commit;
    logic cfg_ready, cfg_active, data_out, carry_out_o;

    int checks = 0;
    int errors = 0;

    carry_slice_output_stage #(
        .CFG_W    (8),
        .INIT_VAL (1'b0)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .lut_out     (lut_out),
        .sum_in      (sum_in),
        .carry_in    (carry_in),
        .ce          (ce),
        .sr          (sr),
        .cfg_bit     (cfg_bit),
        .cfg_shift   (cfg_shift),
        .cfg_commit  (cfg_commit),
        .cfg_ready   (cfg_ready),
        .cfg_active  (cfg_active),
        .data_out    (data_out),
        .carry_out_o (carry_out_o)
    );

    always #5 clk = ~clk;

    // Inputs change 1 time unit after the rising edge; checks happen a further
    // unit later, well clear of the next edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic shift_bits(input logic [7:0] w, input int n);
        for (int i = 0; i < n; i++) begin
            cfg_bit   = w[i];
            cfg_shift = 1'b1;
            tick();
        end
        cfg_shift = 1'b0;
        cfg_bit   = 1'b0;
    endtask

    task automatic commit();
        cfg_commit = 1'b1;
        tick();
        cfg_commit = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; lut_out = 1'b0; sum_in = 1'b0; carry_in = 1'b0;
        ce = 1'b0; sr = 1'b0; cfg_bit = 1'b0; cfg_shift = 1'b0; cfg_commit = 1'b0;
        tick(); tick();

        // Reset state and the unconfigured slice.
        #1;
        chk("rst_data_out", data_out, 1'b0);
        chk("rst_cfg_ready", cfg_ready, 1'b0);
        chk("rst_cfg_active", cfg_active, 1'b0);
        reset = 1'b0;
        tick();
        lut_out = 1'b1; carry_in = 1'b1; sum_in = 1'b1; ce = 1'b1;
        #1;
        chk("nocfg_data_out", data_out, 1'b0);
        chk("nocfg_carry_out", carry_out_o, 1'b0);
        chk("nocfg_cfg_ready", cfg_ready, 1'b0);
        tick();
        chk("nocfg_data_out_after_edge", data_out, 1'b0);
        lut_out = 1'b0; carry_in = 1'b0; sum_in = 1'b0;

        // 8'h01: registered output from lut_out, active-high ce.
        shift_bits(8'h01, 7);
        chk("h01_not_ready_at7", cfg_ready, 1'b0);
        shift_bits(8'h01 >> 7, 1);
        chk("h01_ready_at8", cfg_ready, 1'b1);
        chk("h01_data_before_commit", data_out, 1'b0);
        commit();
        chk("h01_cfg_active", cfg_active, 1'b1);
        chk("h01_ready_cleared", cfg_ready, 1'b0);
        tick();
        lut_out = 1'b1;
        #1;
        chk("h01_reg_not_yet", data_out, 1'b0);
        tick();
        chk("h01_reg_next_cycle", data_out, 1'b1);
        carry_in = 1'b1;
        #1;
        chk("h01_carry_comb", carry_out_o, 1'b1);
        carry_in = 1'b0;

        // 8'h02: comb output from sum_in; shifting must not disturb the live output.
        shift_bits(8'h02, 8);
        chk("h02_shift_no_glitch", data_out, 1'b1);
        commit();
        sum_in = 1'b1; lut_out = 1'b0;
        #1;
        chk("h02_sum_comb_1", data_out, 1'b1);
        sum_in = 1'b0; lut_out = 1'b1;
        #1;
        chk("h02_lut_ignored", data_out, 1'b0);

        // 8'h15: registered, sr_val=1, ce active-low.
        shift_bits(8'h15, 8);
        commit();
        chk("h15_init_after_commit", data_out, 1'b0);
        sr = 1'b1; ce = 1'b0;
        tick();
        chk("h15_sr_sets", data_out, 1'b1);
        sr = 1'b0; ce = 1'b1; lut_out = 1'b0;
        tick();
        chk("h15_ce_inactive_hold", data_out, 1'b1);
        ce = 1'b0;
        tick();
        chk("h15_ce_active_load", data_out, 1'b0);

        // Commit after a partial word is ignored and does not reset the count.
        lut_out = 1'b1; ce = 1'b1;
        shift_bits(8'h1F, 5);
        chk("partial_not_ready", cfg_ready, 1'b0);
        commit();
        chk("partial_commit_ignored", data_out, 1'b0);
        chk("partial_still_not_ready", cfg_ready, 1'b0);
        shift_bits(8'h00, 3);
        chk("partial_count_kept", cfg_ready, 1'b1);
        ce = 1'b0;
        tick();
        chk("pre_reset_data_out", data_out, 1'b1);

        // Reset while full discards everything and quiets outputs at once.
        reset = 1'b1; carry_in = 1'b1;
        #1;
        chk("reset_cycle_data_out", data_out, 1'b0);
        chk("reset_cycle_carry_out", carry_out_o, 1'b0);
        tick();
        reset = 1'b0;
        #1;
        chk("post_reset_ready", cfg_ready, 1'b0);
        chk("post_reset_active", cfg_active, 1'b0);
        chk("post_reset_data_out", data_out, 1'b0);
        carry_in = 1'b0;

        // Commit and shift together: commit takes 8'h02, the bit starts 8'h01.
        shift_bits(8'h02, 8);
        cfg_commit = 1'b1; cfg_shift = 1'b1; cfg_bit = 1'b1;
        tick();
        cfg_commit = 1'b0; cfg_shift = 1'b0; cfg_bit = 1'b0;
        chk("dual_active", cfg_active, 1'b1);
        chk("dual_not_ready", cfg_ready, 1'b0);
        sum_in = 1'b1; lut_out = 1'b0;
        #1;
        chk("dual_comb_sum", data_out, 1'b1);
        shift_bits(8'h00, 6);
        chk("dual_ready_at7", cfg_ready, 1'b0);
        shift_bits(8'h00, 1);
        chk("dual_ready_at8", cfg_ready, 1'b1);
        commit();
        chk("dual_new_reg_init", data_out, 1'b0);
        ce = 1'b1; lut_out = 1'b1;
        tick();
        chk("dual_new_reg_load", data_out, 1'b1);

        // 8'h20 preceded by a junk bit: last eight bits win while full.
        shift_bits(8'h01, 1);
        shift_bits(8'h20, 8);
        chk("h20_ready", cfg_ready, 1'b1);
        commit();
        lut_out = 1'b1;
        #1;
        chk("h20_comb_lut", data_out, 1'b1);
        carry_in = 1'b0;
        tick();
        carry_in = 1'b1;
        #1;
`ifdef CARRY_OUT_REG_EN
        chk("h20_carry_cycle_n", carry_out_o, 1'b0);
`else
        chk("h20_carry_cycle_n", carry_out_o, 1'b1);
`endif
        tick();
        carry_in = 1'b0;
        #1;
`ifdef CARRY_OUT_REG_EN
        chk("h20_carry_cycle_n1", carry_out_o, 1'b1);
`else
        chk("h20_carry_cycle_n1", carry_out_o, 1'b0);
`endif
        tick();
        chk("h20_carry_settled", carry_out_o, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
